ddr2_init_seq: RTL and testbench
================================

# ddr2_init_seq

Power-up initialization sequencer for the DDR2 DIMM command bus. Out of reset it drives CKE, chip-select, command, bank and address lines through the JEDEC DDR2 initialization sequence:
- power-up wait
- precharge-all
- EMRS2/EMRS3/EMRS1
- MRS with DLL reset
- precharge-all
- two auto-refreshes
- final MRS
- optional OCD calibration

It then asserts `init_done`. It sits in the controller ahead of the command mux, which hands the bus to the main scheduler once `init_done` is high.

## Interface
Parameters:
- `BA_WIDTH`, 3, bank address width; matches `` `DRAM_BA_WIDTH ``.
- `ADDR_WIDTH`, 14, row/mode address width; matches `` `DRAM_ADDR_WIDTH ``.
- `T_PWRUP`, 40000, cycles with CKE low after reset (200 us).
- `T_CKE`, 80, NOP cycles after CKE rises, before the first command (400 ns).
- `T_RP`, 4, cycles from PRECHARGE to the next command.
- `T_MRD`, 2, cycles from MRS/EMRS to the next command.
- `T_RFC`, 26, cycles from REFRESH to the next command.
- `T_DLLK`, 200, minimum cycles from the DLL-reset MRS to `init_done`.
- `MR_VAL`, 14'h0442, MR contents; bit 8 is forced by the sequencer.
- `EMR_VAL`, 14'h0004, EMR1 contents; bits 9:7 are forced by the sequencer.

Ports:
- `clk` in 1: controller clock; DIMM `ck` is derived from it.
- `rst_n` in 1: reset; synchronous to `clk`, active-low.
- `cke` out 1: clock enable.
- `cs_n`, `ras_n`, `cas_n`, `we_n` out 1 each: command lines.
- `ba` out `BA_WIDTH`: bank / mode register select.
- `addr` out `ADDR_WIDTH`: address / mode register value.
- `odt` out 1: on-die termination; held 0.
- `init_done` out 1: sequence complete; sticky until reset.
- `init_state` out 5: current FSM state encoding, for debug.

## Operation
All outputs are registered.

Reset values (while `rst_n`=0 at a `clk` edge):
- `cke`=0, `cs_n`=0, `ras_n`=1, `cas_n`=1, `we_n`=1 (NOP).
- `ba`=0, `addr`=0, `odt`=0, `init_done`=0, state=`PWRUP`.

Command encodings {cs_n,ras_n,cas_n,we_n}:
- NOP 0111
- PRE 0010
- REF 0001
- MRS 0000

FSM states, in order. Each command state drives its command for exactly one cycle, then waits its gap.
- `PWRUP`: CKE=0, NOP for `T_PWRUP` cycles.
- `CKEWAIT`: CKE=1, NOP for `T_CKE` cycles.
- `PRE1`: PRE with addr[10]=1, ba=0; gap `T_RP`.
- `EMR2`: MRS, ba=2, addr=0; gap `T_MRD`.
- `EMR3`: MRS, ba=3, addr=0; gap `T_MRD`.
- `EMR1`: MRS, ba=1, addr=`EMR_VAL` with [9:7]=000; gap `T_MRD`.
- `MRDLL`: MRS, ba=0, addr=`MR_VAL` with [8]=1; gap `T_MRD`. Starts the DLL counter.
- `PRE2`: as `PRE1`.
- `REF1`: REF; gap `T_RFC`.
- `REF2`: REF; gap `T_RFC`.
- `MRFIN`: MRS, ba=0, addr=`MR_VAL` with [8]=0; gap `T_MRD`.
- `OCDDEF`, `OCDEXIT`: see Configuration.
- `DLLWAIT`: NOP until the DLL counter has expired.
- `DONE`: `init_done`=1, NOP, CKE=1. Terminal.

Gap and counter rules:
- Between commands the sequencer drives NOP. `ba`/`addr` return to 0 in the cycle after each command.
- A single gap counter, 16 bits, is loaded with (gap − 1) on the command cycle. The next state's command issues on the cycle after the counter reaches 0.
- A gap parameter < 1 is treated as 1.
- The DLL counter is independent and 8+ bits wide, sized for `T_DLLK`. It is loaded in the `MRDLL` command cycle and decrements every cycle, saturating at 0.

Boundary conditions:
- `rst_n` low in any state returns to `PWRUP` with the reset values on the next edge. No partial command is ever emitted.
- After `init_done` the outputs never change until reset.

## Timing
- `MRDLL` command at cycle N: `init_done` rises no earlier than cycle N+`T_DLLK`. It also rises no earlier than one cycle after the last command gap ends, whichever is later.
- First PRE issues at cycle `T_PWRUP`+`T_CKE` after reset release; CKE rises at cycle `T_PWRUP`.
- Command-to-command spacing is exactly the stated gap; no extra idle cycles.

## Configuration
- Macro `DDR2_INIT_OCD_EN`.
- Defined: after `MRFIN`, two extra commands are inserted before `DLLWAIT`.
  - `OCDDEF`: MRS, ba=1, addr=`EMR_VAL` with [9:7]=111; gap `T_MRD`.
  - `OCDEXIT`: MRS, ba=1, addr=`EMR_VAL` with [9:7]=000; gap `T_MRD`.
- Undefined: `MRFIN` proceeds directly to `DLLWAIT`. The `OCDDEF`/`OCDEXIT` state encodings are unused.

## Test plan
- Small parameters (`T_PWRUP`=10, `T_CKE`=4, `T_RP`=2, `T_MRD`=2, `T_RFC`=5, `T_DLLK`=30), OCD off, release reset at cycle 0. Required response:
  - CKE rises at cycle 10.
  - PRE (addr[10]=1) at cycle 14.
  - EMR2 at 16, EMR3 at 18, EMR1 at 20, MRDLL at 22 (addr[8]=1).
  - PRE at 24, REF at 26 and 31, MRFIN at 36 (addr[8]=0).
  - `init_done` rises at cycle 52 (22+30).
- Same run with `T_DLLK`=2: `init_done` rises at cycle 38, gated by the `MRFIN` gap rather than the DLL counter.
- `DDR2_INIT_OCD_EN` defined, same parameters as the first run:
  - ba=1 MRS with addr[9:7]=111 at cycle 38.
  - ba=1 MRS with addr[9:7]=000 at cycle 40.
  - `init_done` at cycle 52.
- Assert `rst_n`=0 for one cycle during the `REF1` gap. Required response:
  - `cke`=0 and NOP on the next edge.
  - The full sequence replays, with identical cycle offsets, from the release.
- Hold reset low for 100 cycles: all outputs stay at their reset values and `init_done`=0 throughout.
- Run 1000 cycles past `init_done`: `init_done`=1, `cke`=1 and NOP stay constant every cycle, and `odt`=0 throughout.

Source files
------------

// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer driving CKE and the DIMM command/address bus.
// Define DDR2_INIT_OCD_EN to insert the OCD default/exit EMRS pair after the final MRS.
module ddr2_init_seq #(
  parameter int unsigned                BA_WIDTH   = 3,
  parameter int unsigned                ADDR_WIDTH = 14,
  parameter int                         T_PWRUP    = 40000,
  parameter int                         T_CKE      = 80,
  parameter int                         T_RP       = 4,
  parameter int                         T_MRD      = 2,
  parameter int                         T_RFC      = 26,
  parameter int                         T_DLLK     = 200,
  parameter logic [ADDR_WIDTH-1:0]      MR_VAL     = ADDR_WIDTH'(14'h0442),
  parameter logic [ADDR_WIDTH-1:0]      EMR_VAL    = ADDR_WIDTH'(14'h0004)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  cke,
  output logic                  cs_n,
  output logic                  ras_n,
  output logic                  cas_n,
  output logic                  we_n,
  output logic [BA_WIDTH-1:0]   ba,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  odt,
  output logic                  init_done,
  output logic [4:0]            init_state
);

  typedef enum logic [4:0] {
    PWRUP   = 5'd0,
    CKEWAIT = 5'd1,
    PRE1    = 5'd2,
    EMR2    = 5'd3,
    EMR3    = 5'd4,
    EMR1    = 5'd5,
    MRDLL   = 5'd6,
    PRE2    = 5'd7,
    REF1    = 5'd8,
    REF2    = 5'd9,
    MRFIN   = 5'd10,
    OCDDEF  = 5'd11,
    OCDEXIT = 5'd12,
    DLLWAIT = 5'd13,
    DONE    = 5'd14
  } state_t;

  localparam int unsigned CNT_W   = 16;
  localparam int          G_PWRUP = (T_PWRUP < 1) ? 1 : T_PWRUP;
  localparam int          G_CKE   = (T_CKE   < 1) ? 1 : T_CKE;
  localparam int          G_RP    = (T_RP    < 1) ? 1 : T_RP;
  localparam int          G_MRD   = (T_MRD   < 1) ? 1 : T_MRD;
  localparam int          G_RFC   = (T_RFC   < 1) ? 1 : T_RFC;
  localparam int          G_DLLK  = (T_DLLK  < 1) ? 1 : T_DLLK;
  localparam int unsigned DLL_W   = ($clog2(G_DLLK) > 8) ? $clog2(G_DLLK) : 8;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [ADDR_WIDTH-1:0] MR_DLL   = MR_VAL  |  ADDR_WIDTH'(14'h0100);
  localparam logic [ADDR_WIDTH-1:0] MR_FIN   = MR_VAL  & ~ADDR_WIDTH'(14'h0100);
  localparam logic [ADDR_WIDTH-1:0] EMR_OCD0 = EMR_VAL & ~ADDR_WIDTH'(14'h0380);
`ifdef DDR2_INIT_OCD_EN
  localparam logic [ADDR_WIDTH-1:0] EMR_OCD1 = EMR_VAL |  ADDR_WIDTH'(14'h0380);
`endif

  state_t                  state, state_nxt, step;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [DLL_W-1:0]        dll, dll_nxt;
  logic                    adv;
  logic                    cke_nxt, done_nxt;
  logic [3:0]              cmd_nxt;
  logic [BA_WIDTH-1:0]     ba_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;

  assign init_state = state;

  // Successor of each state and whether its wait has expired this cycle
  always_comb begin
    step = PWRUP;
    adv  = (cnt == '0);
    unique case (state)
      PWRUP:   step = CKEWAIT;
      CKEWAIT: step = PRE1;
      PRE1:    step = EMR2;
      EMR2:    step = EMR3;
      EMR3:    step = EMR1;
      EMR1:    step = MRDLL;
      MRDLL:   step = PRE2;
      PRE2:    step = REF1;
      REF1:    step = REF2;
      REF2:    step = MRFIN;
`ifdef DDR2_INIT_OCD_EN
      MRFIN:   step = OCDDEF;
      OCDDEF:  step = OCDEXIT;
      OCDEXIT: step = (dll == '0) ? DONE : DLLWAIT;
`else
      MRFIN:   step = (dll == '0) ? DONE : DLLWAIT;
`endif
      DLLWAIT: begin
        step = DONE;
        adv  = (dll == '0);
      end
      DONE: begin
        step = DONE;
        adv  = 1'b0;
      end
      default: begin
        step = PWRUP;
        adv  = 1'b1;
      end
    endcase
  end

  // Next-state, gap/DLL counters and the command presented on entry to each state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    dll_nxt   = (dll != '0) ? dll - DLL_W'(1) : dll;
    cmd_nxt   = CMD_NOP;
    ba_nxt    = '0;
    addr_nxt  = '0;
    if (adv) begin
      state_nxt = step;
      unique case (step)
        CKEWAIT: cnt_nxt = CNT_W'(G_CKE - 1);
        PRE1, PRE2: begin
          cmd_nxt      = CMD_PRE;
          addr_nxt[10] = 1'b1;
          cnt_nxt      = CNT_W'(G_RP - 1);
        end
        EMR2: begin
          cmd_nxt = CMD_MRS;
          ba_nxt  = BA_WIDTH'(2);
          cnt_nxt = CNT_W'(G_MRD - 1);
        end
        EMR3: begin
          cmd_nxt = CMD_MRS;
          ba_nxt  = BA_WIDTH'(3);
          cnt_nxt = CNT_W'(G_MRD - 1);
        end
        EMR1: begin
          cmd_nxt  = CMD_MRS;
          ba_nxt   = BA_WIDTH'(1);
          addr_nxt = EMR_OCD0;
          cnt_nxt  = CNT_W'(G_MRD - 1);
        end
        MRDLL: begin
          cmd_nxt  = CMD_MRS;
          addr_nxt = MR_DLL;
          cnt_nxt  = CNT_W'(G_MRD - 1);
          dll_nxt  = DLL_W'(G_DLLK - 1);
        end
        REF1, REF2: begin
          cmd_nxt = CMD_REF;
          cnt_nxt = CNT_W'(G_RFC - 1);
        end
        MRFIN: begin
          cmd_nxt  = CMD_MRS;
          addr_nxt = MR_FIN;
          cnt_nxt  = CNT_W'(G_MRD - 1);
        end
`ifdef DDR2_INIT_OCD_EN
        OCDDEF: begin
          cmd_nxt  = CMD_MRS;
          ba_nxt   = BA_WIDTH'(1);
          addr_nxt = EMR_OCD1;
          cnt_nxt  = CNT_W'(G_MRD - 1);
        end
        OCDEXIT: begin
          cmd_nxt  = CMD_MRS;
          ba_nxt   = BA_WIDTH'(1);
          addr_nxt = EMR_OCD0;
          cnt_nxt  = CNT_W'(G_MRD - 1);
        end
`endif
        default: ;
      endcase
    end
    cke_nxt  = (state_nxt != PWRUP);
    done_nxt = (state_nxt == DONE);
  end

  // Cycle 0 is the first edge after release, so the power-up count starts one higher
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= PWRUP;
      cnt                       <= CNT_W'(G_PWRUP);
      dll                       <= '0;
      cke                       <= 1'b0;
      {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
      ba                        <= '0;
      addr                      <= '0;
      odt                       <= 1'b0;
      init_done                 <= 1'b0;
    end else begin
      state                     <= state_nxt;
      cnt                       <= cnt_nxt;
      dll                       <= dll_nxt;
      cke                       <= cke_nxt;
      {cs_n, ras_n, cas_n, we_n} <= cmd_nxt;
      ba                        <= ba_nxt;
      addr                      <= addr_nxt;
      odt                       <= 1'b0;
      init_done                 <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Scoreboard bench for ddr2_init_seq: expected bus events are queued by the driver and
// matched by a negedge monitor; a second instance with a short DLL lock time checks done gating.
module tb_ddr2_init_seq;

  localparam logic [3:0]  NOP = 4'b0111;
  localparam logic [3:0]  PRE = 4'b0010;
  localparam logic [3:0]  REF = 4'b0001;
  localparam logic [3:0]  MRS = 4'b0000;
  localparam logic [13:0] MR  = 14'h0542;
  localparam logic [13:0] EMR = 14'h0284;
`ifdef DDR2_INIT_OCD_EN
  localparam int DONE2_CYC = 42;
`else
  localparam int DONE2_CYC = 38;
`endif

  typedef struct packed {
    int          cyc;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        cke;
    logic        done;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke, cs_n, ras_n, cas_n, we_n, odt, init_done;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic [4:0]  init_state;
  logic        cke2, cs_n2, ras_n2, cas_n2, we_n2, odt2, init_done2;
  logic [2:0]  ba2;
  logic [13:0] addr2;
  logic [4:0]  init_state2;

  int   checks = 0;
  int   failures = 0;
  int   cyc = -1;
  logic rst_q = 1'b0;
  logic cke_q = 1'b0, done_q = 1'b0, done2_q = 1'b0;
  ev_t  exp_q[$];
  int   exp2_q[$];

  ddr2_init_seq #(
    .BA_WIDTH(3), .ADDR_WIDTH(14), .T_PWRUP(10), .T_CKE(4), .T_RP(2), .T_MRD(2),
    .T_RFC(5), .T_DLLK(30), .MR_VAL(MR), .EMR_VAL(EMR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .odt(odt), .init_done(init_done),
    .init_state(init_state)
  );

  ddr2_init_seq #(
    .BA_WIDTH(3), .ADDR_WIDTH(14), .T_PWRUP(10), .T_CKE(4), .T_RP(2), .T_MRD(2),
    .T_RFC(5), .T_DLLK(2), .MR_VAL(MR), .EMR_VAL(EMR)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .cke(cke2), .cs_n(cs_n2), .ras_n(ras_n2), .cas_n(cas_n2),
    .we_n(we_n2), .ba(ba2), .addr(addr2), .odt(odt2), .init_done(init_done2),
    .init_state(init_state2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [3:0] k, input logic [2:0] b,
                             input logic [13:0] a, input logic e, input logic d);
    ev_t v;
    v.cyc = c; v.cmd = k; v.ba = b; v.addr = a; v.cke = e; v.done = d;
    return v;
  endfunction

  // Queue the hand-derived event list for one release, keeping events before 'upto'
  task automatic push_run(input int upto);
    ev_t t[$];
    t.push_back(mk(10, NOP, 3'd0, 14'h0000, 1'b1, 1'b0));
    t.push_back(mk(14, PRE, 3'd0, 14'h0400, 1'b1, 1'b0));
    t.push_back(mk(16, MRS, 3'd2, 14'h0000, 1'b1, 1'b0));
    t.push_back(mk(18, MRS, 3'd3, 14'h0000, 1'b1, 1'b0));
    t.push_back(mk(20, MRS, 3'd1, 14'h0004, 1'b1, 1'b0));
    t.push_back(mk(22, MRS, 3'd0, 14'h0542, 1'b1, 1'b0));
    t.push_back(mk(24, PRE, 3'd0, 14'h0400, 1'b1, 1'b0));
    t.push_back(mk(26, REF, 3'd0, 14'h0000, 1'b1, 1'b0));
    t.push_back(mk(31, REF, 3'd0, 14'h0000, 1'b1, 1'b0));
    t.push_back(mk(36, MRS, 3'd0, 14'h0442, 1'b1, 1'b0));
`ifdef DDR2_INIT_OCD_EN
    t.push_back(mk(38, MRS, 3'd1, 14'h0384, 1'b1, 1'b0));
    t.push_back(mk(40, MRS, 3'd1, 14'h0004, 1'b1, 1'b0));
`endif
    t.push_back(mk(52, NOP, 3'd0, 14'h0000, 1'b1, 1'b1));
    foreach (t[i]) if (t[i].cyc < upto) exp_q.push_back(t[i]);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!init_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(init_done), 64'(1));
  endtask

  always @(posedge clk) begin
    rst_q <= rst_n;
    cyc   <= rst_n ? cyc + 1 : -1;
  end

  // Monitor: reset values, bus events against the queue, post-done stability
  always @(negedge clk) begin : mon
    logic [3:0] c;
    ev_t        e;
    int         e2;
    c = {cs_n, ras_n, cas_n, we_n};
    if (!rst_q) begin
      check("reset_vals", {cke, c, ba, addr, odt, init_done, init_state},
            {1'b0, NOP, 3'd0, 14'd0, 1'b0, 1'b0, 5'd0});
      check("reset_vals2", {cke2, cs_n2, ras_n2, cas_n2, we_n2, ba2, addr2, odt2, init_done2,
            init_state2}, {1'b0, NOP, 3'd0, 14'd0, 1'b0, 1'b0, 5'd0});
      cke_q   <= 1'b0;
      done_q  <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      check("odt_low", {odt, odt2}, 2'b00);
      if ((cke && !cke_q) || c != NOP || (init_done && !done_q)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event cyc=%0d cmd=%b ba=%0d addr=%h", cyc, c, ba, addr);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("event_cyc%0d", e.cyc), {32'(cyc), c, ba, addr, cke, init_done},
                {32'(e.cyc), e.cmd, e.ba, e.addr, e.cke, e.done});
        end
      end
      if (done_q)
        check("post_done_stable", {cke, c, ba, addr, init_done}, {1'b1, NOP, 3'd0, 14'd0, 1'b1});
      if (init_done2 && !done2_q) begin
        if (exp2_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done2 cyc=%0d", cyc);
        end else begin
          e2 = exp2_q.pop_front();
          check("done2_cyc", 64'(cyc), 64'(e2));
        end
      end
      cke_q   <= cke;
      done_q  <= init_done;
      done2_q <= init_done2;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (100) @(negedge clk);

    push_run(1000);
    exp2_q.push_back(DONE2_CYC);
    rst_n = 1'b1;
    wait_done(200);
    repeat (1000) @(negedge clk);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    push_run(28);
    rst_n = 1'b1;
    repeat (28) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("partial_run_drained", 64'(exp_q.size()), 64'(0));
    push_run(1000);
    exp2_q.push_back(DONE2_CYC);
    rst_n = 1'b1;
    wait_done(200);
    repeat (10) @(negedge clk);

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("exp2_q_empty", 64'(exp2_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
